// File: rtl/router_fsm_nch.sv
// Router controller FSM for NUM_CH output channels.
// Decodes the header address, sequences header/payload/parity/full recovery,
// drops packets with invalid addresses and, optionally, packets stalled too
// long waiting for an empty FIFO.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   pkt_valid           source packet valid
//   parity_done         parity byte captured by the register block
//   low_pkt_valid       pkt_valid fell during FIFO-full handling
//   fifo_full           full flag of the selected FIFO
//   soft_reset[NUM_CH]  per-channel soft reset (read timeout)
//   fifo_empty[NUM_CH]  per-channel empty flags
//   data_in[ADDR_W]     header address bits
//   busy .. drop_state  Moore decode of the current state
//   dest_sel            latched destination of the current packet
//   wait_timeout        one-cycle pulse when the wait timeout expires
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 0,
  parameter int TO_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [ADDR_W-1:0] data_in,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic [ADDR_W-1:0] dest_sel,
  output logic              wait_timeout
);

  typedef enum logic [3:0] {
    S_DECODE,
    S_LFD,
    S_LD,
    S_FULL,
    S_LAF,
    S_LP,
    S_CPE,
    S_WAIT,
    S_DROP
  } state_t;

  // Channel vectors are widened to the full address space so any
  // dest_sel/data_in value indexes a defined bit (unused channels read 0).
  localparam int NSEL = 1 << ADDR_W;

  localparam logic [ADDR_W:0] NUM_LIM =
    (ADDR_W+1)'(NUM_CH);

  localparam bit TO_EN = (WAIT_TIMEOUT > 0);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TO_EN ? WAIT_TIMEOUT - 1 : 0);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] dest_d;
  logic [TO_W-1:0]   cnt_q;
  logic [TO_W-1:0]   cnt_d;
  logic              to_q;
  logic              to_d;

  logic [NSEL-1:0]   empty_x;
  logic [NSEL-1:0]   srst_x;
  logic              addr_ok;
  logic              srst_hit;

  assign empty_x = NSEL'(fifo_empty);
  assign srst_x  = NSEL'(soft_reset);
  assign addr_ok = {1'b0, data_in} < NUM_LIM;

  // Soft reset only matters while a packet owns dest_sel's FIFO.
  assign srst_hit = srst_x[dest_q]
                 && (state_q != S_DECODE)
                 && (state_q != S_DROP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_DECODE;
      dest_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    if (srst_hit) begin
      state_d = S_DECODE;
    end else begin
      unique case (state_q)
        S_DECODE: begin
          if (pkt_valid) begin
            dest_d = data_in;
            cnt_d  = '0;
            if (!addr_ok)
              state_d = S_DROP;
            else if (empty_x[data_in])
              state_d = S_LFD;
            else
              state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // An empty FIFO wins over an expiring timeout.
          if (empty_x[dest_q]) begin
            state_d = S_LFD;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            state_d = S_DROP;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_LFD: state_d = S_LD;
        S_LD: begin
          if (fifo_full)
            state_d = S_FULL;
          else if (!pkt_valid)
            state_d = S_LP;
        end
        S_FULL: begin
          if (!fifo_full)
            state_d = S_LAF;
        end
        S_LAF: begin
          if (parity_done)
            state_d = S_DECODE;
          else if (low_pkt_valid)
            state_d = S_LP;
          else
            state_d = S_LD;
        end
        S_LP: state_d = S_CPE;
        S_CPE: begin
          if (fifo_full)
            state_d = S_FULL;
          else
            state_d = S_DECODE;
        end
        S_DROP: begin
          if (!pkt_valid)
            state_d = S_DECODE;
        end
        default: state_d = S_DECODE;
      endcase
    end
  end

  always_comb begin
    busy          = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    drop_state    = 1'b0;
    unique case (state_q)
      S_DECODE: detect_add = 1'b1;
      S_LFD: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      S_LD: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      S_FULL: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      S_LAF: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      S_LP: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      S_CPE: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      // busy stays low so the source drains the dropped packet.
      S_DROP: drop_state = 1'b1;
      default: detect_add = 1'b0;
    endcase
  end

  assign dest_sel     = dest_q;
  assign wait_timeout = to_q;

endmodule
